mips_mc_control: RTL and testbench
==================================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter WAIT_MEM, default 1: 1 = memory states wait on mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 clk  input  1  system clock, rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 opcode  input  6  instruction[31:26], from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst  output  1 each  datapath strobes and mux selects.
REQ-008 pcsource  output  2  PC mux select: 00 ALU, 01 ALUOut, 10 jump target.
REQ-009 alusrcb  output  2  ALU B mux select: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
REQ-010 aluop1, aluop0  output  1 each  ALU-control class: 00 add, 01 subtract, 10 funct-decoded.
REQ-011 pc_en  output  1  PC load enable.
REQ-012 illegal_op  output  1  sticky flag: unsupported opcode was decoded.

Function
REQ-013 The block SHALL be a Moore FSM; all outputs except pc_en, irwrite and pcwrite are decoded from the current state only.
REQ-014 pc_en SHALL equal pcwrite OR (pcwritecond AND zero), combinationally.
REQ-015 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-016 States, asserted outputs, and transitions (unlisted outputs = 0):
- IDLE: all outputs 0. Next state: FETCH.
- FETCH: memread=1, alusrcb=01; irwrite=pcwrite=mem_ready. Holds until mem_ready, then DECODE.
- DECODE: alusrcb=11, aluop=00. Next state by opcode:
  - lw/sw -> MEMADR
  - R-type -> RTYPE_EX
  - beq -> BEQ
  - j -> JUMP
  - addi -> ADDI_EX
  - other -> FETCH, and illegal_op is set.
- MEMADR: alusrca=1, alusrcb=10. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1. Next: FETCH.
- MEMWR: memwrite=1, iord=1. Holds until mem_ready, then FETCH.
- RTYPE_EX: alusrca=1, aluop=10. Next: RTYPE_WB.
- RTYPE_WB: regdst=1, regwrite=1. Next: FETCH.
- BEQ: alusrca=1, aluop=01, pcwritecond=1, pcsource=01. Next: FETCH.
- JUMP: pcwrite=1, pcsource=10. Next: FETCH.
- ADDI_EX: alusrca=1, alusrcb=10. Next: ADDI_WB.
- ADDI_WB: regwrite=1. Next: FETCH.
REQ-017 opcode SHALL be sampled only in DECODE and MEMADR; changes in any other state have no effect.
REQ-018 In a waiting state, memread/memwrite/iord SHALL stay asserted every cycle until mem_ready.
REQ-019 mem_ready asserted outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-020 Instruction cycle counts with mem_ready always 1:
- lw: 5
- sw, R-type, addi: 4
- beq, j: 3
- illegal opcode: 2
REQ-021 illegal_op SHALL be cleared only by reset; repeated illegal opcodes leave it at 1.

Reset
REQ-022 While rst_n=0, state = IDLE and illegal_op = 0, asynchronously; every output, including pc_en, is therefore 0.
REQ-023 Reset asserted mid-instruction (including during a mem wait) SHALL abort the instruction immediately; no further strobes are issued.
REQ-024 After rst_n deasserts, the first rising edge moves IDLE -> FETCH.

Structure
REQ-025 Package mips_ctrl_pkg SHALL hold the opcode constants, the state enumeration (4-bit binary encoding) and the encodings for pcsource, alusrcb and aluop.
REQ-026 One sub-module, mips_ctrl_outdec, SHALL contain the state-to-output decode; the next-state logic and state register stay in mips_mc_control.

Verification
REQ-027 Reset release, mem_ready=1, opcode=100011 -> states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; memtoreg=1 and regwrite=1 only in MEMWB.
REQ-028 opcode=000100: zero=1 -> pc_en=1 in the BEQ cycle with pcsource=01; zero=0 -> pc_en=0 in BEQ.
REQ-029 sw with mem_ready held 0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; the WAIT_MEM=0 build takes 1 cycle.
REQ-030 opcode=111111 in DECODE -> next state FETCH, illegal_op=1 and still 1 after a following R-type instruction; cleared only by rst_n=0.
REQ-031 rst_n pulsed low during MEMRD -> all outputs 0 within the same cycle; FETCH on the first edge after release.
REQ-032 R-type then j (mem_ready=1) -> aluop=10 in RTYPE_EX, regdst=1 and regwrite=1 in RTYPE_WB; then pcwrite=1 and pcsource=10 in JUMP; 4 + 3 cycles.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, FSM states and datapath select encodings for the multicycle MIPS control
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE_EX, S_RTYPE_WB, S_BEQ, S_JUMP, S_ADDI_EX, S_ADDI_WB
    } state_t;

    typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10} pcsrc_t;
    typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SL2 = 2'b11} srcb_t;
    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} aluop_t;
endpackage

// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if: control-to-datapath bundle; master is the controller, slave is the datapath
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic       zero, mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst;
    logic [1:0] pcsource, alusrcb;
    logic       aluop1, aluop0, pc_en, illegal_op;
    modport master (
        input  opcode, zero, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst,
        output pcsource, alusrcb, aluop1, aluop0, pc_en, illegal_op
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst,
        input  pcsource, alusrcb, aluop1, aluop0, pc_en, illegal_op
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: state-to-strobe decode; only the FETCH write strobes look at memory readiness
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     st,
    input  logic       rdy,
    output logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst,
    output logic [1:0] pcsource, alusrcb, aluop
);
    // decode datapath controls from the current state
    always_comb begin
        pcwrite = 1'b0; pcwritecond = 1'b0; iord = 1'b0; memread = 1'b0; memwrite = 1'b0;
        memtoreg = 1'b0; irwrite = 1'b0; alusrca = 1'b0; regwrite = 1'b0; regdst = 1'b0;
        pcsource = PCS_ALU; alusrcb = SRCB_REG; aluop = ALUOP_ADD;
        case (st)
            S_FETCH:    begin memread = 1'b1; alusrcb = SRCB_FOUR; irwrite = rdy; pcwrite = rdy; end
            S_DECODE:   alusrcb = SRCB_IMM_SL2;
            S_MEMADR:   begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
            S_MEMRD:    begin memread = 1'b1; iord = 1'b1; end
            S_MEMWB:    begin regwrite = 1'b1; memtoreg = 1'b1; end
            S_MEMWR:    begin memwrite = 1'b1; iord = 1'b1; end
            S_RTYPE_EX: begin alusrca = 1'b1; aluop = ALUOP_FUNCT; end
            S_RTYPE_WB: begin regdst = 1'b1; regwrite = 1'b1; end
            S_BEQ:      begin alusrca = 1'b1; aluop = ALUOP_SUB; pcwritecond = 1'b1; pcsource = PCS_ALUOUT; end
            S_JUMP:     begin pcwrite = 1'b1; pcsource = PCS_JUMP; end
            S_ADDI_EX:  begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
            S_ADDI_WB:  regwrite = 1'b1;
            default:    ;
        endcase
    end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control FSM with optional memory wait handshake
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter bit WAIT_MEM = 1'b1
)(
    input  logic               clk,
    input  logic               rst_n,
    mips_mc_control_if.master  bus
);
    state_t     state, state_nx;
    logic       rdy, illegal, illegal_set;
    logic [1:0] aluop;

    assign rdy = !WAIT_MEM || bus.mem_ready;

    // next state; opcode only matters in DECODE and MEMADR
    always_comb begin
        state_nx = S_FETCH;
        illegal_set = 1'b0;
        case (state)
            S_IDLE:     state_nx = S_FETCH;
            S_FETCH:    state_nx = rdy ? S_DECODE : S_FETCH;
            S_DECODE:
                case (bus.opcode)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_RTYPE_EX;
                    OP_BEQ:       state_nx = S_BEQ;
                    OP_J:         state_nx = S_JUMP;
                    OP_ADDI:      state_nx = S_ADDI_EX;
                    default:      illegal_set = 1'b1;
                endcase
            S_MEMADR:   state_nx = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_nx = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_nx = rdy ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: state_nx = S_RTYPE_WB;
            S_ADDI_EX:  state_nx = S_ADDI_WB;
            default:    state_nx = S_FETCH;
        endcase
    end

    // state register and sticky illegal-opcode flag, both cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            illegal <= 1'b0;
        end else begin
            state   <= state_nx;
            illegal <= illegal | illegal_set;
        end
    end

    mips_ctrl_outdec u_outdec (
        .st(state), .rdy(rdy),
        .pcwrite(bus.pcwrite), .pcwritecond(bus.pcwritecond), .iord(bus.iord), .memread(bus.memread),
        .memwrite(bus.memwrite), .memtoreg(bus.memtoreg), .irwrite(bus.irwrite), .alusrca(bus.alusrca),
        .regwrite(bus.regwrite), .regdst(bus.regdst), .pcsource(bus.pcsource), .alusrcb(bus.alusrcb),
        .aluop(aluop)
    );

    assign {bus.aluop1, bus.aluop0} = aluop;
    assign bus.pc_en = bus.pcwrite | (bus.pcwritecond & bus.zero);
    assign bus.illegal_op = illegal;
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: randomized instruction streams checked cycle by cycle against a per-instruction step model
module tb_mips_mc_control;
    import mips_ctrl_pkg::*;

    localparam logic [17:0] PCW = 18'h20000, PWC = 18'h10000, IORD = 18'h08000, MR = 18'h04000, MW = 18'h02000;
    localparam logic [17:0] MTR = 18'h01000, IRW = 18'h00800, ASA = 18'h00400, RW = 18'h00200, RD = 18'h00100;
    localparam logic [17:0] PCEN = 18'h00002;

    logic clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
    int   tests = 0, fails = 0;
    logic ill_m = 1'b0;
    logic [17:0] obs_a, obs_b;

    always #5 clk = ~clk;

    mips_mc_control_if a();
    mips_mc_control_if b();
    mips_mc_control dut (.clk(clk), .rst_n(rst_n), .bus(a));
    mips_mc_control #(.WAIT_MEM(1'b0)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(b));

    assign obs_a = {a.pcwrite, a.pcwritecond, a.iord, a.memread, a.memwrite, a.memtoreg, a.irwrite, a.alusrca,
                    a.regwrite, a.regdst, a.pcsource, a.alusrcb, a.aluop1, a.aluop0, a.pc_en, a.illegal_op};
    assign obs_b = {b.pcwrite, b.pcwritecond, b.iord, b.memread, b.memwrite, b.memtoreg, b.irwrite, b.alusrca,
                    b.regwrite, b.regdst, b.pcsource, b.alusrcb, b.aluop1, b.aluop0, b.pc_en, b.illegal_op};

    function automatic logic [17:0] pcs(input logic [1:0] v); return {10'b0, v, 6'b0}; endfunction
    function automatic logic [17:0] sb(input logic [1:0] v);  return {12'b0, v, 4'b0}; endfunction
    function automatic logic [17:0] aop(input logic [1:0] v); return {14'b0, v, 2'b0}; endfunction
    function automatic logic [5:0] junk(); return 6'($urandom); endfunction
    function automatic logic rbit(); return 1'($urandom); endfunction
    function automatic logic legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive inputs, check outputs mid-cycle, advance past the next edge
    task automatic step(input string tag, input logic [17:0] base, input logic rdy, input logic [5:0] op, input logic z);
        logic [17:0] e;
        a.mem_ready = rdy; a.opcode = op; a.zero = z;
        e = base;
        e[1] = e[17] | (e[16] & z);
        e[0] = ill_m;
        #1 check(tag, obs_a, e);
        @(posedge clk); #1;
    endtask

    task automatic mem_phase(input string tag, input logic [17:0] base, input int w);
        for (int i = 0; i < w; i++) step({tag, "_wait"}, base, 1'b0, junk(), rbit());
        step(tag, base, 1'b1, junk(), rbit());
    endtask

    task automatic instr(input logic [5:0] op, input int wf, input int wm, input logic z);
        mem_phase("fetch", MR | sb(2'b01) | ((wf < 0) ? 18'h0 : 18'h0), wf > 0 ? wf : 0);
        step("decode", sb(2'b11), rbit(), op, rbit());
        if (!legal(op)) ill_m = 1'b1;
        case (op)
            OP_LW: begin
                step("memadr_lw", ASA | sb(2'b10), rbit(), op, rbit());
                mem_phase("memrd", MR | IORD, wm);
                step("memwb", RW | MTR, rbit(), junk(), rbit());
            end
            OP_SW: begin
                step("memadr_sw", ASA | sb(2'b10), rbit(), op, rbit());
                mem_phase("memwr", MW | IORD, wm);
            end
            OP_RTYPE: begin
                step("rtype_ex", ASA | aop(2'b10), rbit(), junk(), rbit());
                step("rtype_wb", RD | RW, rbit(), junk(), rbit());
            end
            OP_BEQ:  step("beq", ASA | aop(2'b01) | PWC | pcs(2'b01), rbit(), junk(), z);
            OP_J:    step("jump", PCW | pcs(2'b10), rbit(), junk(), rbit());
            OP_ADDI: begin
                step("addi_ex", ASA | sb(2'b10), rbit(), junk(), rbit());
                step("addi_wb", RW, rbit(), junk(), rbit());
            end
            default: ;
        endcase
    endtask

    // the FETCH cycle that completes also raises irwrite/pcwrite, so mem_phase's final step needs them
    task automatic run(input logic [5:0] op, input int wf, input int wm, input logic z);
        for (int i = 0; i < wf; i++) step("fetch_wait", MR | sb(2'b01), 1'b0, junk(), rbit());
        step("fetch", MR | sb(2'b01) | IRW | PCW, 1'b1, junk(), rbit());
        step("decode", sb(2'b11), rbit(), op, rbit());
        if (!legal(op)) ill_m = 1'b1;
        case (op)
            OP_LW: begin
                step("memadr_lw", ASA | sb(2'b10), rbit(), op, rbit());
                mem_phase("memrd", MR | IORD, wm);
                step("memwb", RW | MTR, rbit(), junk(), rbit());
            end
            OP_SW: begin
                step("memadr_sw", ASA | sb(2'b10), rbit(), op, rbit());
                mem_phase("memwr", MW | IORD, wm);
            end
            OP_RTYPE: begin
                step("rtype_ex", ASA | aop(2'b10), rbit(), junk(), rbit());
                step("rtype_wb", RD | RW, rbit(), junk(), rbit());
            end
            OP_BEQ:  step("beq", ASA | aop(2'b01) | PWC | pcs(2'b01), rbit(), junk(), z);
            OP_J:    step("jump", PCW | pcs(2'b10), rbit(), junk(), rbit());
            OP_ADDI: begin
                step("addi_ex", ASA | sb(2'b10), rbit(), junk(), rbit());
                step("addi_wb", RW, rbit(), junk(), rbit());
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0]  ops [8];
        logic [17:0] exp2 [6];
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'b111111, 6'b000001};
        a.mem_ready = 1'b0; a.opcode = '0; a.zero = 1'b1;
        b.mem_ready = 1'b0; b.opcode = OP_SW; b.zero = 1'b0;
        #3 check("reset_async", obs_a, 18'h0);
        @(posedge clk); #1;
        a.mem_ready = 1'b1; a.opcode = OP_J;
        #1 check("reset_held", obs_a, 18'h0);
        rst_n = 1'b1;
        step("idle", 18'h0, 1'b1, OP_LW, 1'b1);
        run(OP_LW, 0, 0, 1'b0);
        run(OP_BEQ, 0, 0, 1'b1);
        run(OP_BEQ, 0, 0, 1'b0);
        run(OP_SW, 1, 3, 1'b0);
        run(6'b111111, 0, 0, 1'b0);
        run(OP_RTYPE, 0, 0, 1'b0);
        run(OP_J, 0, 0, 1'b0);
        run(6'b010101, 0, 0, 1'b0);
        for (int n = 0; n < 40; n++)
            run(ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3), rbit());
        run(OP_ADDI, 0, 0, 1'b0);
        step("fetch", MR | sb(2'b01) | IRW | PCW, 1'b1, junk(), rbit());
        step("decode", sb(2'b11), 1'b1, OP_LW, rbit());
        step("memadr_lw", ASA | sb(2'b10), 1'b1, OP_LW, rbit());
        step("memrd_wait", MR | IORD, 1'b0, junk(), 1'b1);
        a.mem_ready = 1'b0;
        #1 check("memrd_pre_reset", obs_a, MR | IORD | {17'b0, ill_m});
        rst_n = 1'b0;
        ill_m = 1'b0;
        #1 check("reset_mid_memrd", obs_a, 18'h0);
        a.mem_ready = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_held", obs_a, 18'h0);
        rst_n = 1'b1;
        step("idle_after_reset", 18'h0, 1'b1, OP_LW, rbit());
        run(OP_RTYPE, 0, 0, 1'b0);
        exp2 = '{18'h0, MR | sb(2'b01) | IRW | PCW | PCEN, sb(2'b11), ASA | sb(2'b10), MW | IORD, MR | sb(2'b01) | IRW | PCW | PCEN};
        rst2_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 check("nowait_sw", obs_b, exp2[i]);
            @(posedge clk); #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
